pe_simd: RTL and testbench
==========================

PE_SIMD -- requirements
Module: pe_simd

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel pixel/coeff multiplies per beat.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8: bits per pixel lane.
REQ-003 SHALL have parameter COEFF_WIDTH, default 8: bits per coefficient lane.
REQ-004 SHALL have parameter ACCUM_WIDTH, default 24: accumulator and result width; must be >= PIXEL_WIDTH+COEFF_WIDTH+clog2(LANES).
REQ-005 SHALL have parameter SIGNED, default 0: 1 = two's-complement operands and result; 0 = unsigned.
REQ-006 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow; 0 = modulo wrap.
REQ-007 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-009 SHALL have port in_valid  input  1  input beat present.
REQ-010 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-011 SHALL have port in_pixel  input  LANES*PIXEL_WIDTH  packed pixels, lane 0 at LSBs.
REQ-012 SHALL have port in_coeff  input  LANES*COEFF_WIDTH  packed coefficients, lane 0 at LSBs.
REQ-013 SHALL have port in_first  input  1  beat starts a new accumulation.
REQ-014 SHALL have port in_last  input  1  beat ends the accumulation and produces a result.
REQ-015 SHALL have port out_valid  output  1  result held in out_acc.
REQ-016 SHALL have port out_ready  input  1  consumer takes the result.
REQ-017 SHALL have port out_acc  output  ACCUM_WIDTH  accumulated dot-product result.
REQ-018 SHALL have port out_sat  output  1  saturation occurred within this result's accumulation.

Function
REQ-019 SHALL accept a beat when in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-020 SHALL, while stalled (in_ready=0), freeze all pipeline stages, accumulator and out_acc/out_sat.
REQ-021 Stage 1 SHALL register the LANES products with in_first/in_last/valid; each product is PIXEL_WIDTH+COEFF_WIDTH bits, sign- or zero-extended per SIGNED.
REQ-022 Stage 2 SHALL sum all stage-1 products, width PIXEL_WIDTH+COEFF_WIDTH+clog2(LANES), extended to ACCUM_WIDTH+1 bits.
REQ-023 Stage 2 SHALL load acc = sum when first is set (or when the previous beat was last), else acc = acc + sum.
REQ-024 SHALL detect overflow on each stage-2 update: unsigned above 2^ACCUM_WIDTH-1; signed outside [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1].
REQ-025 With SATURATE=1, SHALL clamp acc to the violated bound and set a sticky sat bit; with SATURATE=0, SHALL keep the low ACCUM_WIDTH bits and never set sat.
REQ-026 SHALL clear the sticky sat bit on a first beat, before applying that beat's own overflow.
REQ-027 On a stage-2 beat with last set, SHALL load out_acc/out_sat with the final value and assert out_valid the next cycle.
REQ-028 Latency SHALL be 2 cycles from the accepted last beat to out_valid=1, absent stalls.
REQ-029 A beat with both first and last set SHALL yield a single-beat result.
REQ-030 SHALL drop out_valid after the out_valid && out_ready cycle unless a new result loads that same cycle; back-to-back results lose nothing.
REQ-031 SHALL ignore in_pixel, in_coeff, in_first and in_last when in_valid=0; pipeline bubbles leave acc unchanged.

Reset
REQ-032 On rst=1 at a clock edge, SHALL set out_valid=0, out_acc=0, out_sat=0, acc=0, sticky sat=0, and all stage valids=0.
REQ-033 in_ready SHALL be 1 during and immediately after reset.
REQ-034 Reset mid-accumulation SHALL discard the partial sum; no result is emitted for it.

Verification
REQ-035 Defaults; pixels {1,2,3,4}, coeffs {5,6,7,8}, first=last=1 -> out_valid 2 cycles later, out_acc=70, out_sat=0.
REQ-036 Defaults; 3 beats of all lanes 255x255 (first on beat 1, last on beat 3) -> out_acc=780300, out_sat=0.
REQ-037 ACCUM_WIDTH=18, SATURATE=1; 2 beats of all 255x255 -> out_acc=262143, out_sat=1; same stimulus with SATURATE=0 -> out_acc=258056, out_sat=0.
REQ-038 SIGNED=1; pixels all -128, coeffs all 127, single beat -> out_acc=0xFF0200 (-65024), out_sat=0.
REQ-039 Result pending with out_ready=0 for 5 cycles -> in_ready=0, out_acc stable; with out_ready=1 -> next result correct, no beat lost or duplicated.
REQ-040 rst pulsed after 2 of 3 beats -> out_valid=0 next cycle; then a fresh first/last beat {1,1,1,1}x{2,2,2,2} -> out_acc=8.

Source files
------------

// File: rtl/pe_simd.sv
// pe_simd: LANES-wide pixel x coefficient dot-product engine with a running
// accumulator. Stage 1 registers the per-lane products. Stage 2 adds them into
// the accumulator, clamping or wrapping on overflow. A beat marked last also
// loads the output register. A held result (out_valid && !out_ready) freezes
// the whole pipe.

// One multiplier lane with its stage-1 product register.
module pe_lane #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int SIGNED      = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [PIXEL_WIDTH-1:0]             pixel,
  input  logic [COEFF_WIDTH-1:0]             coeff,
  output logic [PIXEL_WIDTH+COEFF_WIDTH-1:0] prod
);
  localparam int PW = PIXEL_WIDTH + COEFF_WIDTH;
  localparam bit SG = (SIGNED != 0);

  // Extend both operands to the full product width first. The low PW bits of
  // the product are then correct for both the signed and the unsigned case.
  logic [PW-1:0] px, cx;
  assign px = {{COEFF_WIDTH{SG & pixel[PIXEL_WIDTH-1]}}, pixel};
  assign cx = {{PIXEL_WIDTH{SG & coeff[COEFF_WIDTH-1]}}, coeff};

  // Stage-1 product register; only loads on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst)     prod <= '0;
    else if (en) prod <= px * cx;
  end
endmodule

module pe_simd #(
  parameter int LANES       = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int ACCUM_WIDTH = 24,
  parameter int SIGNED      = 0,
  parameter int SATURATE    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*PIXEL_WIDTH-1:0] in_pixel,
  input  logic [LANES*COEFF_WIDTH-1:0] in_coeff,
  input  logic                         in_first,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACCUM_WIDTH-1:0]       out_acc,
  output logic                         out_sat
);
  localparam int PW = PIXEL_WIDTH + COEFF_WIDTH;
  // Two headroom bits: enough for acc + sum in either signedness, with a
  // spare sign bit, so the bound compares can always be done as signed.
  localparam int EW = ACCUM_WIDTH + 2;
  localparam bit SG = (SIGNED != 0);
  localparam bit ST = (SATURATE != 0);

  localparam logic [EW-1:0] MAXV = SG ? {3'b000, {(ACCUM_WIDTH-1){1'b1}}}
                                      : {2'b00, {ACCUM_WIDTH{1'b1}}};
  localparam logic [EW-1:0] MINV = SG ? {3'b111, {(ACCUM_WIDTH-1){1'b0}}}
                                      : {EW{1'b0}};

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } s1_t;

  logic [LANES-1:0][PW-1:0] prod;
  s1_t                      s1;
  logic [ACCUM_WIDTH-1:0]   acc, acc_nxt;
  logic                     sat, sat_nxt, prev_last;
  logic [EW-1:0]            sum, base, nxt;
  logic                     start, hi, lo, beat_en;

  assign in_ready = !(out_valid && !out_ready);
  assign beat_en  = in_valid && in_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pe_lane #(
      .PIXEL_WIDTH(PIXEL_WIDTH),
      .COEFF_WIDTH(COEFF_WIDTH),
      .SIGNED     (SIGNED)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (beat_en),
      .pixel(in_pixel[l*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .coeff(in_coeff[l*COEFF_WIDTH +: COEFF_WIDTH]),
      .prod (prod[l])
    );
  end

  // Lane adder tree: extend each product to the working width, then sum.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + {{(EW-PW){SG & prod[i][PW-1]}}, prod[i]};
  end

  // A new accumulation starts on first, or on the beat right after a last.
  assign start = s1.first | prev_last;
  assign base  = start ? '0 : {{2{SG & acc[ACCUM_WIDTH-1]}}, acc};
  assign nxt   = base + sum;
  assign hi    = $signed(nxt) > $signed(MAXV);
  assign lo    = $signed(nxt) < $signed(MINV);

  // Overflow handling: clamp to the violated bound with sticky sat, or wrap.
  always_comb begin
    acc_nxt = nxt[ACCUM_WIDTH-1:0];
    sat_nxt = 1'b0;
    if (ST) begin
      sat_nxt = (!start & sat) | hi | lo;
      if (hi)      acc_nxt = MAXV[ACCUM_WIDTH-1:0];
      else if (lo) acc_nxt = MINV[ACCUM_WIDTH-1:0];
    end
  end

  // Stage-1 control, stage-2 accumulator and the output register all advance
  // together and all hold while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      prev_last <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else if (in_ready) begin
      s1 <= '{vld: in_valid, first: in_valid & in_first, last: in_valid & in_last};
      if (s1.vld) begin
        acc       <= acc_nxt;
        sat       <= sat_nxt;
        prev_last <= s1.last;
      end
      out_valid <= s1.vld & s1.last;
      if (s1.vld & s1.last) begin
        out_acc <= acc_nxt;
        out_sat <= sat_nxt;
      end
    end
  end
endmodule

// File: tb/tb_pe_simd.sv
// Bench for pe_simd. Four instances share one stimulus stream:
// default unsigned/24b/saturating, unsigned 18b saturating, unsigned 18b
// wrapping, and signed 18b saturating. An arithmetic reference model queues
// the expected results; a monitor pops and compares them on each output
// handshake.
module tb_pe_simd;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_first, in_last, out_ready;
  logic [31:0] in_pixel, in_coeff;
  logic [3:0]  ir, ov, os;
  logic [23:0] oa0;
  logic [17:0] oa1, oa2, oa3;

  int n_checks = 0;
  int n_err    = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  pe_simd u_d0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_pixel(in_pixel), .in_coeff(in_coeff), .in_first(in_first), .in_last(in_last),
    .out_valid(ov[0]), .out_ready(out_ready), .out_acc(oa0), .out_sat(os[0]));
  pe_simd #(.ACCUM_WIDTH(18), .SATURATE(1)) u_d1 (.clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[1]), .in_pixel(in_pixel), .in_coeff(in_coeff),
    .in_first(in_first), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
    .out_acc(oa1), .out_sat(os[1]));
  pe_simd #(.ACCUM_WIDTH(18), .SATURATE(0)) u_d2 (.clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[2]), .in_pixel(in_pixel), .in_coeff(in_coeff),
    .in_first(in_first), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
    .out_acc(oa2), .out_sat(os[2]));
  pe_simd #(.ACCUM_WIDTH(18), .SIGNED(1), .SATURATE(1)) u_d3 (.clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[3]), .in_pixel(in_pixel), .in_coeff(in_coeff),
    .in_first(in_first), .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready),
    .out_acc(oa3), .out_sat(os[3]));

  // ---------------- reference model ----------------
  typedef struct { longint acc; bit sat; } exp_t;
  exp_t   q0[$], q1[$], q2[$], q3[$];
  int     cw[4];
  bit     csg[4], cst[4];
  longint macc[4];
  bit     msat[4], mprev[4];

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic qpush(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic qpop(int i, output exp_t e);
    case (i)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      2: e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int i = 0; i < 4; i++) begin
      macc[i] = 0; msat[i] = 1'b0; mprev[i] = 1'b0;
    end
  endtask

  // Plain integer dot product, then range check against the configured width.
  task automatic model_beat(logic [31:0] px, logic [31:0] cf, bit first, bit last);
    for (int i = 0; i < 4; i++) begin
      longint dot = 0;
      longint m   = 64'sd1 <<< cw[i];
      longint hi  = csg[i] ? (m / 2) - 1 : m - 1;
      longint lo  = csg[i] ? -(m / 2) : 0;
      for (int l = 0; l < 4; l++) begin
        logic [7:0] pb, cb;
        longint p, c;
        pb = px[l*8 +: 8];
        cb = cf[l*8 +: 8];
        p = csg[i] ? longint'($signed(pb)) : longint'(pb);
        c = csg[i] ? longint'($signed(cb)) : longint'(cb);
        dot += p * c;
      end
      if (first || mprev[i]) begin
        macc[i] = 0; msat[i] = 1'b0;
      end
      macc[i] += dot;
      if (macc[i] > hi || macc[i] < lo) begin
        if (cst[i]) begin
          macc[i] = (macc[i] > hi) ? hi : lo;
          msat[i] = 1'b1;
        end else begin
          longint v = macc[i] % m;
          if (v < 0) v += m;
          if (csg[i] && v >= m / 2) v -= m;
          macc[i] = v;
        end
      end
      mprev[i] = last;
      if (last) begin
        exp_t e;
        e.acc = macc[i] & (m - 1);
        e.sat = msat[i];
        qpush(i, e);
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, longint act, longint expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint out_acc_of(int i);
    case (i)
      0: return longint'(oa0);
      1: return longint'(oa1);
      2: return longint'(oa2);
      default: return longint'(oa3);
    endcase
  endfunction

  // Scoreboard monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i]) begin
          if (qsize(i) == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_result d%0d: got acc %0d, none expected", i, out_acc_of(i));
          end else begin
            exp_t e;
            qpop(i, e);
            chk($sformatf("acc_d%0d", i), out_acc_of(i), e.acc);
            chk($sformatf("sat_d%0d", i), longint'(os[i]), longint'(e.sat));
          end
        end
      end
    end
  end

  // Random consumer back-pressure when enabled.
  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus ----------------
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic send(logic [31:0] px, logic [31:0] cf, bit first, bit last);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1; in_pixel = px; in_coeff = cf; in_first = first; in_last = last;
    while (!ok && n < 200) begin
      @(negedge clk); ok = ir[0];
      @(posedge clk); #1; n++;
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", n);
    end else model_beat(px, cf, first, last);
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      in_valid = 1'b0; in_pixel = $urandom; in_coeff = $urandom;
      in_first = 1'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    chk("in_ready_in_reset", longint'(ir[0]), 1);
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid_d%0d", i), longint'(ov[i]), 0);
      chk($sformatf("rst_acc_d%0d", i), out_acc_of(i), 0);
      chk($sformatf("rst_sat_d%0d", i), longint'(os[i]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", longint'(ir[0]), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    while ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    idle(3);
    chk("drain_pending", longint'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 0);
  endtask

  initial begin
    cw  = '{24, 18, 18, 18};
    csg = '{0, 0, 0, 1};
    cst = '{1, 1, 0, 1};
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_pixel = '0; in_coeff = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Single-beat dot product and its 2-cycle latency.
    send(32'h04030201, 32'h08070605, 1, 1);
    @(negedge clk);
    chk("latency_early", longint'(ov[0]), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("latency_valid", longint'(ov[0]), 1);
    @(posedge clk); #1;
    drain();

    // Three max beats, then two max beats (18b saturate/wrap cases).
    for (int b = 0; b < 3; b++) send(32'hFFFFFFFF, 32'hFFFFFFFF, b == 0, b == 2);
    for (int b = 0; b < 2; b++) send(32'hFFFFFFFF, 32'hFFFFFFFF, b == 0, b == 1);
    // Signed -128 x 127 single beat.
    send(32'h80808080, 32'h7F7F7F7F, 1, 1);
    // Long run pushes the 24-bit accumulator into saturation.
    for (int b = 0; b < 66; b++) send(32'hFFFFFFFF, 32'hFFFFFFFF, b == 0, b == 65);
    // A beat after a last starts fresh even without first.
    send(32'h01010101, 32'h02020202, 1, 1);
    send(32'h01010101, 32'h03030303, 0, 1);
    drain();

    // Held result: input blocked, output frozen, then nothing lost or doubled.
    out_ready = 1'b0;
    send(32'h04030201, 32'h01010101, 1, 1);
    send(32'h01020304, 32'h02020202, 1, 1);
    in_valid = 1'b1; in_pixel = 32'h05050505; in_coeff = 32'h03030303;
    in_first = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", longint'(ir[0]), 0);
      chk("stall_valid", longint'(ov[0]), 1);
      if (q0.size() > 0) chk("stall_acc_stable", longint'(oa0), q0[0].acc);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h05050505, 32'h03030303, 1, 1);
    drain();

    // Reset in the middle of an accumulation.
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    do_reset();
    send(32'h01010101, 32'h02020202, 1, 1);
    drain();
    send(32'h01010101, 32'h01010101, 1, 0);
    do_reset();
    send(32'h01010101, 32'h03030303, 0, 1);
    drain();

    // Randomized groups with random bubbles and back-pressure.
    rand_rdy = 1'b1;
    for (int g = 0; g < 80; g++) begin
      int len  = $urandom_range(1, 5);
      int mode = $urandom_range(0, 3);
      for (int b = 0; b < len; b++) begin
        logic [31:0] px, cf;
        case (mode)
          0: begin px = $urandom; cf = $urandom; end
          1: begin px = 32'hFFFFFFFF; cf = 32'hFFFFFFFF; end
          2: begin px = 32'h80808080; cf = 32'h80808080; end
          default: begin px = 32'h80808080; cf = 32'h7F7F7F7F; end
        endcase
        send(px, cf, b == 0, b == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
